// File: rtl/aemb_wbmem_pkg.sv
// Shared types and helpers for the dual-port wishbone test memory.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
package aemb_wbmem_pkg;

    // Per-port bus handshake state
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } port_state_t;

    // Bitmap indexed by sel: single bytes, aligned halfwords, full word
    localparam logic [15:0] SEL_LEGAL = 16'b1001_0001_0001_1110;

    // Fibonacci taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic sel_legal(input logic [3:0] sel);
        return SEL_LEGAL[sel];
    endfunction

    // sel[3] owns bits 31:24, sel[0] owns bits 7:0
    function automatic logic [31:0] lane_merge(input logic [31:0] old_w,
                                               input logic [31:0] new_w,
                                               input logic [3:0]  sel);
        logic [31:0] m;
        m = old_w;
        for (int b = 0; b < 4; b++) begin
            if (sel[b]) m[8*b +: 8] = new_w[8*b +: 8];
        end
        return m;
    endfunction

    function automatic logic [15:0] lfsr_next(input logic [15:0] s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/aemb_wbmem_port.sv
// One bus port sequencer: IDLE -> optional WAIT countdown -> one-cycle RESP.
// Latency: ack/err (wait+1) cycles after stb is first sampled; wait = FIXWAIT + masked random.
// Backpressure: master holds stb until ack/err; dropping stb during WAIT abandons the access.
module aemb_wbmem_port
    import aemb_wbmem_pkg::*;
#(
    parameter int         FIXWAIT = 0,
    parameter logic [3:0] RNDMSK  = 4'h0
) (
    input  logic       sys_clk_i,
    input  logic       sys_rst_i,
    input  logic       stb,
    input  logic       we,
    input  logic [3:0] sel,
    input  logic [3:0] rnd,
    output logic       load,
    output logic       ack,
    output logic       err
);

    port_state_t state;
    logic [4:0]  cnt;
    logic [4:0]  wait_ld;
    logic        bad_sel;
    logic        to_resp;

    assign wait_ld = 5'(FIXWAIT) + {1'b0, rnd & RNDMSK};
    assign bad_sel = we && !sel_legal(sel);

    // Detect the cycle right before RESP; top uses it to capture read data
    always_comb begin
        to_resp = 1'b0;
        case (state)
            ST_IDLE: to_resp = stb && (wait_ld == 5'd0);
            ST_WAIT: to_resp = stb && (cnt == 5'd1);
            default: to_resp = 1'b0;
        endcase
    end

    assign load = to_resp;

    // Handshake FSM with wait counter and registered ack/err
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            state <= ST_IDLE;
            cnt   <= 5'd0;
            ack   <= 1'b0;
            err   <= 1'b0;
        end else begin
            ack <= to_resp && !bad_sel;
            err <= to_resp && bad_sel;
            case (state)
                ST_IDLE: begin
                    if (stb) begin
                        cnt   <= wait_ld;
                        state <= (wait_ld == 5'd0) ? ST_RESP : ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (!stb) begin
                        state <= ST_IDLE;
                    end else begin
                        cnt <= cnt - 5'd1;
                        if (cnt == 5'd1) state <= ST_RESP;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/aemb_wbmem.sv
// Dual-port wishbone memory model: I port read-only, D port read/write with byte lanes.
// Latency: ack (wait+1) cycles after stb; waits fixed per port plus optional LFSR-driven random.
// Backpressure: each port accepts one access at a time; stb low during WAIT aborts it.
module aemb_wbmem
    import aemb_wbmem_pkg::*;
#(
    parameter int          AW     = 14,
    parameter int          IWAIT  = 0,
    parameter int          DWAIT  = 0,
    parameter logic [3:0]  RNDMSK = 4'h0,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_i,
    input  logic [AW-1:0] iwb_adr_i,
    input  logic          iwb_stb_i,
    output logic [31:0]   iwb_dat_o,
    output logic          iwb_ack_o,
    input  logic [AW-1:0] dwb_adr_i,
    input  logic          dwb_stb_i,
    input  logic          dwb_wre_i,
    input  logic [3:0]    dwb_sel_i,
    input  logic [31:0]   dwb_dat_i,
    output logic [31:0]   dwb_dat_o,
    output logic          dwb_ack_o,
    output logic          dwb_err_o
);

    logic [31:0] mem [0:(1<<AW)-1];
    logic [15:0] lfsr;
    logic        i_load;
    logic        d_load;
    logic        i_err_unused;

    // Free-running shared LFSR supplying random wait states to both ports
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) lfsr <= SEED;
        else            lfsr <= lfsr_next(lfsr);
    end

    aemb_wbmem_port #(.FIXWAIT(IWAIT), .RNDMSK(RNDMSK)) u_iport (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .stb       (iwb_stb_i),
        .we        (1'b0),
        .sel       (4'hF),
        .rnd       (lfsr[3:0]),
        .load      (i_load),
        .ack       (iwb_ack_o),
        .err       (i_err_unused)
    );

    aemb_wbmem_port #(.FIXWAIT(DWAIT), .RNDMSK(RNDMSK)) u_dport (
        .sys_clk_i (sys_clk_i),
        .sys_rst_i (sys_rst_i),
        .stb       (dwb_stb_i),
        .we        (dwb_wre_i),
        .sel       (dwb_sel_i),
        .rnd       (lfsr[3:0]),
        .load      (d_load),
        .ack       (dwb_ack_o),
        .err       (dwb_err_o)
    );

    // Read data captured on entry to RESP and held until the next access
    always_ff @(posedge sys_clk_i or negedge sys_rst_i) begin
        if (!sys_rst_i) begin
            iwb_dat_o <= 32'd0;
            dwb_dat_o <= 32'd0;
        end else begin
            if (i_load) iwb_dat_o <= mem[iwb_adr_i];
            if (d_load) dwb_dat_o <= mem[dwb_adr_i];
        end
    end

    // Legal writes commit on the edge that ends RESP; ack is only raised for legal selects
    always_ff @(posedge sys_clk_i) begin
        if (dwb_ack_o && dwb_wre_i && !i_err_unused)
            mem[dwb_adr_i] <= lane_merge(mem[dwb_adr_i], dwb_dat_i, dwb_sel_i);
    end

endmodule

// File: doc/aemb_wbmem.md
AEMB_WBMEM -- requirements
Module: aemb_wbmem

Interface
REQ-001 Parameters SHALL be:
  - AW, default 14: word-address width.
  - IWAIT, default 0: fixed I-port wait states, 0..15.
  - DWAIT, default 0: fixed D-port wait states, 0..15.
  - RNDMSK, default 0: 4-bit mask applied to LFSR bits [3:0] to add random wait states; 0 disables random waits.
  - SEED, default 16'hACE1: LFSR reset value; nonzero.
REQ-002 Ports SHALL be:
  - sys_clk_i  in  1  single clock, all state on rising edge.
  - sys_rst_i  in  1  asynchronous, active-low reset.
  - iwb_adr_i  in  AW  instruction word address.
  - iwb_stb_i  in  1  instruction strobe.
  - iwb_dat_o  out  32  instruction read data.
  - iwb_ack_o  out  1  instruction acknowledge.
  - dwb_adr_i  in  AW  data word address.
  - dwb_stb_i  in  1  data strobe.
  - dwb_wre_i  in  1  data write enable.
  - dwb_sel_i  in  4  byte selects, big-endian: sel[3] maps to bits 31:24, sel[0] to bits 7:0.
  - dwb_dat_i  in  32  write data.
  - dwb_dat_o  out  32  read data.
  - dwb_ack_o  out  1  data acknowledge.
  - dwb_err_o  out  1  data error, illegal select.
REQ-003 Storage SHALL be one shared array of 2**AW 32-bit words, readable by both ports and writable by the D port only.

Function
REQ-004 Each port SHALL run an FSM with states IDLE, WAIT and RESP.
REQ-005 IDLE with stb=1 SHALL load the wait counter with fixed_wait + (lfsr[3:0] & RNDMSK), then go to RESP if the loaded value is 0, else WAIT.
REQ-006 WAIT SHALL decrement the counter each cycle and go to RESP on the cycle the counter reaches 1.
REQ-007 In WAIT, stb=0 SHALL abort: the FSM returns to IDLE, no ack, no err, no write.
REQ-008 RESP SHALL assert ack (or err) for exactly one cycle, then go to IDLE unconditionally; back-to-back accesses therefore cost fixed_wait+2 cycles each.
REQ-009 With zero waits, ack SHALL assert in the cycle after stb is first sampled high.
REQ-010 Read data SHALL be registered from the address presented on the cycle before RESP; the data output is valid only while ack=1 and holds its value otherwise.
REQ-011 Legal select values SHALL be 1, 2, 4, 8, 3, C and F.
REQ-012 A write with a legal select SHALL commit only the selected lanes on the rising edge that ends RESP; unselected lanes are preserved.
REQ-013 A write with an illegal select SHALL assert dwb_err_o in RESP instead of dwb_ack_o and leave memory unmodified; reads ignore the select.
REQ-014 A same-cycle I read and D write to the same word SHALL return the pre-write data to the I port (read-before-write).
REQ-015 A D read in the cycle after a D write to the same word SHALL return the new data.
REQ-016 The LFSR SHALL be 16-bit Fibonacci with taps 16, 14, 13, 11, advancing every cycle out of reset, shared by both ports.
REQ-017 Address, select and write enable SHALL be sampled only at IDLE→WAIT/RESP and at the RESP edge; changes during WAIT are undefined master behaviour and are not checked.

Reset
REQ-018 Assertion (sys_rst_i=0) SHALL immediately force:
  - both FSMs to IDLE;
  - ack and err to 0;
  - dat_o to 0;
  - the LFSR to SEED.
REQ-019 Reset mid-WAIT or mid-RESP SHALL drop the transaction without committing any write.
REQ-020 Memory contents SHALL NOT be reset; the bench preloads them.
REQ-021 The first stb is sampled on the first rising edge after deassertion.

Structure
REQ-022 Package aemb_wbmem_pkg SHALL hold:
  - the FSM state enum;
  - the legal-select constant set;
  - the lane-merge function (old word, new word, sel → merged word);
  - LFSR tap constants.
REQ-023 Sub-module aemb_wbmem_port SHALL implement one FSM plus wait counter and SHALL be instantiated twice, with the I instance's write path tied off.
REQ-024 The top level SHALL own the array, the LFSR and the write merge.

Verification
REQ-025 Zero-wait read: IWAIT=0; preload word 5=32'h11223344; iwb_stb_i=1 at cycle 0 → iwb_ack_o=1 at cycle 1 with iwb_dat_o=32'h11223344, 0 at cycle 2.
REQ-026 Byte-lane write: DWAIT=3; word 8=32'hAABBCCDD; write sel=4'h2, dat=32'h0000EE00 → ack 4 cycles after stb; word 8 reads 32'hAABBEEDD.
REQ-027 Illegal select: write sel=4'h5 → dwb_err_o pulses one cycle, dwb_ack_o stays 0, word unchanged.
REQ-028 Collision: I read and D write to word 3 (old 32'h0, new 32'hFFFFFFFF) acking in the same cycle → I gets 32'h0; a D read next gets 32'hFFFFFFFF.
REQ-029 Abort and reset: DWAIT=5; drop stb after 2 cycles → no ack; repeat, then assert sys_rst_i=0 in WAIT → no write, outputs 0 at once.
REQ-030 Random waits: RNDMSK=4'hF, SEED=16'hACE1; 1000 random accesses checked against a reference model → every latency lies in IWAIT/DWAIT+0..15, and the latency sequence is identical across reruns.
